// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one RV32I ALU between two requesters, with a registered
// response slot. Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_eq,
    output logic        rsp_err
);
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_eq_q, rsp_eq_d;
    logic        rsp_err_q, rsp_err_d;

    logic        free, winner, accept, op_bad;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_eq;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign winner = !req0_valid;
`else
    logic last_grant_q, last_grant_d;

    // Under contention the requester not served last goes first.
    assign winner = (req0_valid & req1_valid) ? ~last_grant_q : !req0_valid;
`endif

    assign free       = !rsp_valid_q | rsp_ready;
    assign req0_ready = free & req0_valid & !winner & !rst;
    assign req1_ready = free & req1_valid & winner & !rst;
    assign accept     = req0_ready | req1_ready;

    assign alu_a  = winner ? req1_a  : req0_a;
    assign alu_b  = winner ? req1_b  : req0_b;
    assign alu_op = winner ? req1_op : req0_op;
    assign op_bad = (alu_op >= 4'd10);

    // Shared combinational ALU.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[4:0];
            4'd6:    alu_result = alu_a >> alu_b[4:0];
            4'd7:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd9:    alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'd0;
        endcase
        alu_eq = (alu_a == alu_b);
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_err_d    = rsp_err_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = winner;
            rsp_result_d = op_bad ? 32'd0 : alu_result;
            rsp_eq_d     = alu_eq;
            rsp_err_d    = op_bad;
        end else if (rsp_valid_q & rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = accept ? winner : last_grant_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_eq_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_err_q    <= rsp_err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_eq     = rsp_eq_q;
    assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the arbitration and response slot.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_eq, rsp_err;
    logic [31:0] rsp_result;

    int n_pass = 0;
    int n_total = 0;

    // Model state: the response slot and who was served last.
    logic        m_valid = 1'b0, m_id = 1'b0, m_eq = 1'b0, m_err = 1'b0, m_last = 1'b1;
    logic [31:0] m_res = 32'd0;
    logic        r0_seen, r1_seen;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b % 32;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return 32'(sa >>> sh);
            8: return (sa < sb) ? 32'd1 : 32'd0;
            9: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready = rr;
    endtask

    // One clock: check readies mid-cycle, advance the model at the edge, check the slot after it.
    task automatic step();
        logic w, e0, e1, free;
        logic [3:0] op;
        logic [31:0] a, b;
        #2;
        free = !m_valid || rsp_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = req0_valid ? 1'b0 : 1'b1;
`else
        if (req0_valid && req1_valid) w = (m_last == 1'b0);
        else w = !req0_valid;
`endif
        e0 = !rst && free && req0_valid && !w;
        e1 = !rst && free && req1_valid && w;
        r0_seen = req0_ready;
        r1_seen = req1_ready;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_res = 0; m_eq = 0; m_err = 0; m_last = 1;
        end else if (e0 || e1) begin
            op = e1 ? req1_op : req0_op;
            a  = e1 ? req1_a  : req0_a;
            b  = e1 ? req1_b  : req0_b;
            m_valid = 1; m_id = e1; m_res = alu_ref(op, a, b);
            m_eq = (a == b); m_err = (op > 9); m_last = e1;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_eq", rsp_eq, m_eq);
        chk("rsp_err", rsp_err, m_err);
    endtask

    initial begin
        logic exp_id;
        logic h0, h1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        step();
        chk("reset_valid", rsp_valid, 0);
        chk("reset_result", rsp_result, 0);
        rst = 1'b0;

        // Single add
        drive(1, 5, 5, 0, 0, 0, 0, 0, 1);
        step();
        chk("add_ready", r0_seen, 1);
        chk("add_result", rsp_result, 32'd10);
        chk("add_eq", rsp_eq, 1);
        chk("add_id", rsp_id, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Contention from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        drive(1, 66, 11, 1, 1, 32'hFFFF_FFF8, 2, 7, 1);
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = 1'(i % 2);
`endif
            chk("rr_id", rsp_id, exp_id);
            chk("rr_result", rsp_result, exp_id ? 32'hFFFF_FFFE : 32'd55);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Backpressure
        drive(1, 32'hFFFF_FFFF, 9, 8, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 9, 9, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_r1", r1_seen, 0);
            chk("bp_result", rsp_result, 1);
            chk("bp_id", rsp_id, 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_accept", r1_seen, 1);
        chk("bp_next_result", rsp_result, 0);
        chk("bp_next_id", rsp_id, 1);

        // Invalid opcode
        drive(0, 0, 0, 0, 1, 3, 4, 12, 1);
        step();
        chk("bad_result", rsp_result, 0);
        chk("bad_err", rsp_err, 1);
        chk("bad_id", rsp_id, 1);

        // Reset mid-operation
        drive(1, 1, 2, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_result", rsp_result, 0);
        drive(1, 7, 7, 0, 1, 8, 8, 0, 1);
        step();
        chk("post_rst_grant", r0_seen, 1);

        // Back-to-back drain and accept
        drive(1, 6, 2, 4, 0, 0, 0, 0, 1);
        step();
        chk("b2b_valid0", rsp_valid, 1);
        chk("b2b_result0", rsp_result, 4);
        drive(1, 5, 6, 3, 0, 0, 0, 0, 1);
        step();
        chk("b2b_valid1", rsp_valid, 1);
        chk("b2b_result1", rsp_result, 7);

        // Random traffic; a stalled request keeps its operands
        for (int i = 0; i < 400; i++) begin
            h0 = req0_valid && !r0_seen && !rst;
            h1 = req1_valid && !r1_seen && !rst;
            rst = ($urandom_range(0, 39) == 0);
            if (!h0) begin
                req0_valid = $urandom_range(0, 2) != 0;
                req0_op = 4'($urandom_range(0, 11));
                req0_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
                req0_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            end
            if (!h1) begin
                req1_valid = $urandom_range(0, 2) != 0;
                req1_op = 4'($urandom_range(0, 11));
                req1_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
                req1_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
